// File: rtl/reg_file_operand_stage.sv
// Register file (1W/2R) with a one-entry operand output register feeding the
// shift/ALU execute stage over a valid/ready handshake.
module reg_file_operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_b_oversize,
    output logic [15:0]       issue_count
);

    // Shift amounts occupy the low bits; anything above them means "> 31".
    localparam int SHAMT_W = 5;

    logic [DATA_W-1:0] regs [NREGS];
    logic              accept;
    logic [DATA_W-1:0] byp_a;
    logic [DATA_W-1:0] byp_b;

    assign issue_ready = !op_valid || op_ready;
    assign accept      = issue_valid && issue_ready;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        byp_a = regs[rs_addr];
        byp_b = regs[rt_addr];
        if (wr_en && (wr_addr == rs_addr)) begin
            byp_a = wr_data;
        end
        if (wr_en && (wr_addr == rt_addr)) begin
            byp_b = wr_data;
        end
    end

    // NOTE: the register array is reset along with the control state because software relies on all registers reading 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            op_valid      <= 1'b0;
            op_a          <= '0;
            op_b          <= '0;
            op_b_oversize <= 1'b0;
            issue_count   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every read above sees pre-edge state, independent of statement order.
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end

            if (accept) begin
                op_valid      <= 1'b1;
                op_a          <= byp_a;
                op_b          <= byp_b;
                op_b_oversize <= |byp_b[DATA_W-1:SHAMT_W];
                issue_count   <= issue_count + 16'd1;
            end else if (op_valid && op_ready) begin
                // Consumed with nothing to replace it: operand values hold.
                op_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_operand_stage.sv
// Self-checking bench for reg_file_operand_stage: directed vector table,
// hand sequences for stall/reset/back-to-back/wrap, then random vs. a model.
module tb_reg_file_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_b_oversize;
    logic [15:0] issue_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_file_operand_stage #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_b_oversize (op_b_oversize),
        .issue_count   (issue_count)
    );

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        issue_valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        op_ready;
        logic        exp_valid;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_over;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs [12];

    // Reference model: architectural register contents plus the pending pair.
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic        m_over;
    logic [15:0] m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        rs_addr     = '0;
        rt_addr     = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        op_ready    = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid = 1'b0;
        m_a     = 32'd0;
        m_b     = 32'd0;
        m_over  = 1'b0;
        m_count = 16'd0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic taken;
        taken = issue_valid && (!m_valid || op_ready);
        if (taken) begin
            m_a     = (wr_en && wr_addr == rs_addr) ? wr_data : m_regs[rs_addr];
            m_b     = (wr_en && wr_addr == rt_addr) ? wr_data : m_regs[rt_addr];
            m_over  = (m_b > 32'd31);
            m_valid = 1'b1;
            m_count = m_count + 16'd1;
        end else if (op_ready) begin
            m_valid = 1'b0;
        end
        if (wr_en) m_regs[wr_addr] = wr_data;
    endtask

    task automatic compare_model();
        check("rnd_op_valid", {31'd0, op_valid}, {31'd0, m_valid});
        check("rnd_op_a", op_a, m_a);
        check("rnd_op_b", op_b, m_b);
        check("rnd_oversize", {31'd0, op_b_oversize}, {31'd0, m_over});
        check("rnd_issue_count", {16'd0, issue_count}, {16'd0, m_count});
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        // Positional: wr_en, wr_addr, wr_data, issue_valid, rs, rt, op_ready,
        //             exp_valid, exp_a, exp_b, exp_over, exp_count
        vecs[0]  = '{1'b1, 5'd3, 32'hF000_000F, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 5'd4, 32'h0000_0004, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 32'hF000_000F, 32'h4, 1'b0, 16'd1};
        vecs[3]  = '{1'b1, 5'd5, 32'h0000_0025, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 32'h25, 32'h25, 1'b1, 16'd2};
        vecs[4]  = '{1'b1, 5'd6, 32'h0000_001F, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h25, 32'h25, 1'b1, 16'd2};
        vecs[5]  = '{1'b1, 5'd7, 32'h0000_0020, 1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 32'h1F, 32'h1F, 1'b0, 16'd3};
        vecs[6]  = '{1'b1, 5'd8, 32'h8000_0000, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 32'h20, 32'h20, 1'b1, 16'd4};
        vecs[7]  = '{1'b1, 5'd9, 32'h0000_0000, 1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 16'd5};
        vecs[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 16'd6};
        vecs[9]  = '{1'b1, 5'd0, 32'h0000_1234, 1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 32'h1234, 32'hF000_000F, 1'b1, 16'd7};
        vecs[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h1234, 32'hF000_000F, 1'b1, 16'd7};
        vecs[11] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 1'b0, 1'b1, 32'h1234, 32'hF000_000F, 1'b1, 16'd7};

        // Power-on reset: outputs must be clear before any clock edge.
        idle_inputs();
        rst = 1'b1;
        #1;
        check("reset_op_valid", {31'd0, op_valid}, 32'd0);
        check("reset_op_a", op_a, 32'd0);
        check("reset_issue_count", {16'd0, issue_count}, 32'd0);
        check("reset_issue_ready", {31'd0, issue_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            wr_en       = vecs[i].wr_en;
            wr_addr     = vecs[i].wr_addr;
            wr_data     = vecs[i].wr_data;
            issue_valid = vecs[i].issue_valid;
            rs_addr     = vecs[i].rs;
            rt_addr     = vecs[i].rt;
            op_ready    = vecs[i].op_ready;
            tick();
            check($sformatf("vec%0d_op_valid", i), {31'd0, op_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_op_a", i), op_a, vecs[i].exp_a);
            check($sformatf("vec%0d_op_b", i), op_b, vecs[i].exp_b);
            check($sformatf("vec%0d_oversize", i), {31'd0, op_b_oversize}, {31'd0, vecs[i].exp_over});
            check($sformatf("vec%0d_issue_count", i), {16'd0, issue_count}, {16'd0, vecs[i].exp_count});
            check($sformatf("vec%0d_issue_ready", i), {31'd0, issue_ready},
                  {31'd0, !vecs[i].exp_valid || vecs[i].op_ready});
        end

        // Stall freeze: r3 rewritten while the pair is held.
        issue_valid = 1'b0;
        op_ready    = 1'b0;
        wr_en       = 1'b1;
        wr_addr     = 5'd3;
        wr_data     = 32'h1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_op_valid", {31'd0, op_valid}, 32'd1);
            check("stall_op_a", op_a, 32'h1234);
            check("stall_op_b", op_b, 32'hF000_000F);
            check("stall_issue_ready", {31'd0, issue_ready}, 32'd0);
            check("stall_issue_count", {16'd0, issue_count}, 32'd7);
        end
        wr_en    = 1'b0;
        op_ready = 1'b1;
        #1;
        check("release_issue_ready_comb", {31'd0, issue_ready}, 32'd1);
        tick();
        check("consume_op_valid", {31'd0, op_valid}, 32'd0);
        check("consume_op_b_hold", op_b, 32'hF000_000F);
        issue_valid = 1'b1;
        rs_addr     = 5'd3;
        rt_addr     = 5'd0;
        tick();
        check("post_stall_op_a", op_a, 32'h1);
        check("post_stall_op_b", op_b, 32'h1234);
        check("post_stall_issue_count", {16'd0, issue_count}, 32'd8);

        // Reset mid-stall: pending pair discarded without a clock edge.
        issue_valid = 1'b0;
        op_ready    = 1'b0;
        tick();
        check("pre_reset_op_valid", {31'd0, op_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_op_valid", {31'd0, op_valid}, 32'd0);
        check("midrst_op_a", op_a, 32'd0);
        check("midrst_op_b", op_b, 32'd0);
        check("midrst_issue_count", {16'd0, issue_count}, 32'd0);
        check("midrst_issue_ready", {31'd0, issue_ready}, 32'd1);
        #2;
        rst = 1'b0;
        op_ready    = 1'b1;
        issue_valid = 1'b1;
        rs_addr     = 5'd7;
        rt_addr     = 5'd7;
        tick();
        check("r7_after_reset", op_a, 32'd0);
        check("r7_after_reset_valid", {31'd0, op_valid}, 32'd1);

        // Back-to-back: r1..r4 loaded, then issued on consecutive cycles.
        issue_valid = 1'b0;
        wr_en       = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            wr_addr = 5'(r);
            wr_data = 32'h1111_1111 * r;
            tick();
        end
        wr_en       = 1'b0;
        issue_valid = 1'b1;
        rt_addr     = 5'd0;
        for (int r = 1; r <= 4; r++) begin
            rs_addr = 5'(r);
            tick();
            check($sformatf("b2b%0d_op_valid", r), {31'd0, op_valid}, 32'd1);
            check($sformatf("b2b%0d_op_a", r), op_a, 32'h1111_1111 * r);
        end
        // One accept (r7 read) plus four back-to-back since the reset.
        check("b2b_issue_count", {16'd0, issue_count}, 32'd5);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            wr_en       = 1'($urandom_range(0, 1));
            wr_addr     = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       wr_data = $urandom;
                1:       wr_data = 32'($urandom_range(0, 63));
                2:       wr_data = 32'd31;
                default: wr_data = 32'd32;
            endcase
            issue_valid = ($urandom_range(0, 3) != 0);
            rs_addr     = 5'($urandom_range(0, 7));
            rt_addr     = 5'($urandom_range(0, 7));
            op_ready    = ($urandom_range(0, 2) != 0);
            #1;
            check("rnd_issue_ready", {31'd0, issue_ready}, {31'd0, !m_valid || op_ready});
            model_step();
            tick();
            compare_model();
        end

        // issue_count wrap.
        do_reset();
        issue_valid = 1'b1;
        op_ready    = 1'b1;
        for (int c = 0; c < 65535; c++) begin
            tick();
        end
        check("count_at_ffff", {16'd0, issue_count}, 32'h0000_FFFF);
        tick();
        check("count_wrap", {16'd0, issue_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
